// File: rtl/switch_merge.sv
// switch_merge: two-to-one merger with a FIFO per input port, round-robin
// arbitration and a registered addr/data output stage with backpressure.
// Optional feature macro: SWITCH_MERGE_ADDR_CHECK_EN drops beats that arrive
// on the wrong port for their address and counts them on drop_cnt.

// Per-port FIFO; pointers wrap naturally because FIFO_DEPTH is a power of 2
module switch_merge_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign dout = mem[rd_ptr];

  // storage: contents are only read when count says they are valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // pointers and occupancy; push+pop together leaves count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module switch_merge #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] ADDR_DIV   = 8'h3F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic                  rdy_a,
  input  logic                  vld_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  rdy_b,
  output logic                  vld,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  src,
  input  logic                  rdy
`ifdef SWITCH_MERGE_ADDR_CHECK_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  // index 0 = port A, index 1 = port B
  logic [1:0]          vld_in, rdy_in, acc, keep, push, pop, nempty;
  beat_t [1:0]         din, dout;
  logic [1:0][CW-1:0]  cnt;
  logic                grant, load, last_grant;

  assign vld_in = {vld_b, vld_a};
  assign din[0] = {addr_a, data_a};
  assign din[1] = {addr_b, data_b};
  assign rdy_a  = rdy_in[0];
  assign rdy_b  = rdy_in[1];

`ifdef SWITCH_MERGE_ADDR_CHECK_EN
  // misrouted beats still handshake but never enter the FIFO
  assign keep[0] = (addr_a <= ADDR_DIV);
  assign keep[1] = (addr_b >  ADDR_DIV);
`else
  assign keep = 2'b11;
`endif

  // ready comes from the registered count only: a full FIFO refuses a push
  // even when it is being popped in the same cycle
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign rdy_in[gi] = !rst && (cnt[gi] != CW'(FIFO_DEPTH));
    assign acc[gi]    = vld_in[gi] && rdy_in[gi];
    assign push[gi]   = acc[gi] && keep[gi];
    assign nempty[gi] = (cnt[gi] != '0);

    switch_merge_fifo #(.W($bits(beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[gi]),
      .din   (din[gi]),
      .pop   (pop[gi]),
      .dout  (dout[gi]),
      .count (cnt[gi])
    );
  end

  // round-robin: a lone requester wins, a tie goes to the port not granted last
  always_comb begin
    grant = 1'b0;
    case (nempty)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = !last_grant;
      default: grant = 1'b0;
    endcase
  end

  assign load = (!vld || rdy) && (nempty != 2'b00);
  assign pop  = load ? (grant ? 2'b10 : 2'b01) : 2'b00;

  // output register; holds addr/data/src while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      vld        <= 1'b0;
      addr       <= '0;
      data       <= '0;
      src        <= 1'b0;
      last_grant <= 1'b1;
    end else if (load) begin
      vld        <= 1'b1;
      addr       <= dout[grant].addr;
      data       <= dout[grant].data;
      src        <= grant;
      last_grant <= grant;
    end else begin
      vld        <= vld && !rdy;
    end
  end

`ifdef SWITCH_MERGE_ADDR_CHECK_EN
  logic [1:0] drops;
  logic [8:0] drop_sum;

  assign drops    = acc & ~keep;
  assign drop_sum = {1'b0, drop_cnt} + 9'(drops[0]) + 9'(drops[1]);

  // saturating count of misrouted beats
  always_ff @(posedge clk) begin
    if (rst) drop_cnt <= '0;
    else     drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end
`endif
endmodule

// File: tb/tb_switch_merge.sv
// tb_switch_merge: randomized and directed stimulus against a queue-based
// reference of the merger, with a scoreboard monitor on the output stream.
module tb_switch_merge;
  localparam int         DEPTH = 4;
  localparam logic [7:0] DIV   = 8'h3F;

  logic        clk = 1'b0, rst = 1'b1;
  logic        vld_a = 1'b0, vld_b = 1'b0, rdy = 1'b0;
  logic [7:0]  addr_a = '0, addr_b = '0;
  logic [15:0] data_a = '0, data_b = '0;
  logic        rdy_a, rdy_b, vld, src;
  logic [7:0]  addr;
  logic [15:0] data;
`ifdef SWITCH_MERGE_ADDR_CHECK_EN
  logic [7:0]  drop_cnt;
`endif

  switch_merge dut (
    .clk(clk), .rst(rst),
    .vld_a(vld_a), .addr_a(addr_a), .data_a(data_a), .rdy_a(rdy_a),
    .vld_b(vld_b), .addr_b(addr_b), .data_b(data_b), .rdy_b(rdy_b),
    .vld(vld), .addr(addr), .data(data), .src(src), .rdy(rdy)
`ifdef SWITCH_MERGE_ADDR_CHECK_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [7:0]  a;
    logic [15:0] d;
  } beat_t;

  beat_t qa[$], qb[$], exp_q[$];
  int    total = 0, bad = 0;
  bit    mlast = 1'b1;
  int    mdrop = 0;

  // reference: port queues hold buffered beats, exp_q holds the beat that
  // should be sitting in the output register
  always @(posedge clk) begin
    bit    acc_a, acc_b, ok_a, ok_b, g;
    beat_t bt;
    if (rst) begin
      qa.delete(); qb.delete(); exp_q.delete();
      mlast = 1'b1;
      mdrop = 0;
    end else begin
      acc_a = vld_a && (qa.size() < DEPTH);
      acc_b = vld_b && (qb.size() < DEPTH);
      ok_a = 1'b1; ok_b = 1'b1;
`ifdef SWITCH_MERGE_ADDR_CHECK_EN
      ok_a = addr_a <= DIV;
      ok_b = addr_b >  DIV;
      mdrop = mdrop + int'(acc_a && !ok_a) + int'(acc_b && !ok_b);
      if (mdrop > 255) mdrop = 255;
`endif
      if (exp_q.size() == 0 && (qa.size() != 0 || qb.size() != 0)) begin
        if (qa.size() == 0)      g = 1'b1;
        else if (qb.size() == 0) g = 1'b0;
        else                     g = !mlast;
        mlast = g;
        bt = g ? qb.pop_front() : qa.pop_front();
        bt.s = g;
        exp_q.push_back(bt);
      end
      if (acc_a && ok_a) qa.push_back('{1'b0, addr_a, data_a});
      if (acc_b && ok_b) qb.push_back('{1'b1, addr_b, data_b});
    end
  end

  // monitor: mid-cycle compare of the presented beat and ready flags
  always @(negedge clk) begin
    bit ea, eb;
    ea = !rst && (qa.size() < DEPTH);
    eb = !rst && (qb.size() < DEPTH);
    total++;
    if (rdy_a !== ea || rdy_b !== eb) begin
      bad++;
      $display("FAIL rdy_ab: got %b%b want %b%b at %0t", rdy_a, rdy_b, ea, eb, $time);
    end
    total++;
    if (vld !== (exp_q.size() != 0)) begin
      bad++;
      $display("FAIL vld: got %b want %b at %0t", vld, exp_q.size() != 0, $time);
    end else if (vld) begin
      total++;
      if (src !== exp_q[0].s || addr !== exp_q[0].a || data !== exp_q[0].d) begin
        bad++;
        $display("FAIL beat: got src=%b addr=%h data=%h want src=%b addr=%h data=%h at %0t",
                 src, addr, data, exp_q[0].s, exp_q[0].a, exp_q[0].d, $time);
      end
    end
`ifdef SWITCH_MERGE_ADDR_CHECK_EN
    total++;
    if (drop_cnt !== 8'(mdrop)) begin
      bad++;
      $display("FAIL drop_cnt: got %0d want %0d at %0t", drop_cnt, mdrop, $time);
    end
`endif
    if (!rst && rdy && exp_q.size() != 0) void'(exp_q.pop_front());
  end

  // hold the given inputs across one rising edge
  task automatic drive(input bit va, input logic [7:0] aa, input logic [15:0] da,
                       input bit vb, input logic [7:0] ab, input logic [15:0] db,
                       input bit r);
    vld_a = va; addr_a = aa; data_a = da;
    vld_b = vb; addr_b = ab; data_b = db;
    rdy = r;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) drive(0, 8'h00, 16'h0, 0, 8'h80, 16'h0, r);
  endtask

  initial begin
    rst = 1'b1;
    idle(2, 1);
    rst = 1'b0;
    // single beat on A
    drive(1, 8'h10, 16'hAAAA, 0, 8'h80, 16'h0, 1);
    idle(4, 1);
    // simultaneous pushes alternate A,B
    for (int i = 1; i <= 4; i++)
      drive(1, 8'(i), 16'(16'h1000 + i), 1, 8'(8'h80 + i), 16'(16'h2000 + i), 1);
    idle(8, 1);
    // fill A with the output stalled, then drain
    for (int i = 0; i < 6; i++) drive(1, 8'(8'h20 + i), 16'(16'h3000 + i), 0, 8'h80, 16'h0, 0);
    idle(10, 1);
    // three-cycle stall on a valid output
    drive(1, 8'h31, 16'h4001, 0, 8'h80, 16'h0, 0);
    drive(1, 8'h32, 16'h4002, 0, 8'h80, 16'h0, 0);
    idle(3, 0);
    idle(4, 1);
    // reset with beats buffered
    for (int i = 0; i < 3; i++) drive(1, 8'(8'h38 + i), 16'(16'h5000 + i), 0, 8'h80, 16'h0, 0);
    rst = 1'b1;
    idle(1, 0);
    rst = 1'b0;
    idle(5, 1);
`ifdef SWITCH_MERGE_ADDR_CHECK_EN
    drive(1, 8'h40, 16'h6000, 1, 8'h3F, 16'h6001, 1);
    idle(3, 1);
    for (int i = 0; i < 150; i++) drive(1, 8'hC0, 16'h7000, 1, 8'h01, 16'h7001, 1);
    idle(3, 1);
`endif
    // random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 1), 8'($urandom), 16'($urandom),
            $urandom_range(0, 1), 8'($urandom), 16'($urandom),
            $urandom_range(0, 9) < 7);
    end
    rst = 1'b0;
    // drain within a bounded window
    for (int i = 0; i < 60 && (qa.size() + qb.size() + exp_q.size()) != 0; i++) idle(1, 1);
    idle(2, 1);
    total++;
    if ((qa.size() + qb.size() + exp_q.size()) != 0) begin
      bad++;
      $display("FAIL drain: %0d beats left want 0", qa.size() + qb.size() + exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
